// File: rtl/lane_temporal_mxu_pkg.sv
// -----------------------------------------------------------------------------
// mxu_pkg
// Shared definitions for the matrix datapath blocks:
//   - mxu_state_t       : control FSM states of the temporal matrix unit
//   - default_out_width : result width that holds a full DIM-term dot product
//   - ext32 / mag32 / neg_of : operand widening, magnitude and sign helpers
// Helpers take the operand zero-extended into 32 bits plus its real width.
// -----------------------------------------------------------------------------
package mxu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_PASS  = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } mxu_state_t;

  function automatic int default_out_width(input int bw, input int dim);
    return 2 * bw + $clog2(dim);
  endfunction

  // Sign- or zero-extend a bw-bit operand held in the low bits of v.
  function automatic logic [31:0] ext32(input logic [31:0] v, input int bw, input logic sgn);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << bw;
    if (sgn && v[bw-1]) begin
      return v | mask;
    end else begin
      return v & ~mask;
    end
  endfunction

  // Magnitude; the most negative signed value yields 2^(bw-1).
  function automatic logic [31:0] mag32(input logic [31:0] v, input int bw, input logic sgn);
    logic [31:0] w;
    w = ext32(v, bw, sgn);
    if (w[31]) begin
      return 32'd0 - w;
    end else begin
      return w;
    end
  endfunction

  function automatic logic neg_of(input logic [31:0] v, input int bw, input logic sgn);
    return sgn & v[bw-1];
  endfunction

endpackage

// File: rtl/lane_temporal_mxu_unary_dot_lane.sv
// -----------------------------------------------------------------------------
// unary_dot_lane
// One unary-binary dot-product engine: each cycle it adds (or subtracts) every
// b element whose paired a magnitude exceeds the pass cycle t.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   i_clear          : zero the accumulator (cycle before each pass)
//   i_en             : pass cycle, accumulate this cycle's sum
//   i_signed_mode    : sign-extend b (else zero-extend)
//   i_mag / i_neg    : magnitudes and signs of one A row
//   i_bcol           : one B column
//   i_t              : pass cycle index
//   o_acc            : accumulator (registered)
// -----------------------------------------------------------------------------
module unary_dot_lane
  import mxu_pkg::*;
#(
  parameter int DIM           = 16,
  parameter int BIT_WIDTH     = 8,
  parameter int OUT_BIT_WIDTH = default_out_width(BIT_WIDTH, DIM),
  parameter int MAG_W         = BIT_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_clear,
  input  logic                     i_en,
  input  logic                     i_signed_mode,
  input  logic [DIM*MAG_W-1:0]     i_mag,
  input  logic [DIM-1:0]           i_neg,
  input  logic [DIM*BIT_WIDTH-1:0] i_bcol,
  input  logic [MAG_W-1:0]         i_t,
  output logic [OUT_BIT_WIDTH-1:0] o_acc
);

  logic [OUT_BIT_WIDTH-1:0] r_acc;
  logic [OUT_BIT_WIDTH-1:0] w_sum;
  logic [OUT_BIT_WIDTH-1:0] w_bext;
  logic [BIT_WIDTH-1:0]     w_b;
  logic [MAG_W-1:0]         w_m;

  // Sum of this cycle's contributions across all k (wraps modulo 2^OUT_BIT_WIDTH).
  always_comb begin
    w_sum  = '0;
    w_bext = '0;
    w_b    = '0;
    w_m    = '0;
    for (int k = 0; k < DIM; k++) begin
      w_b    = i_bcol[k*BIT_WIDTH +: BIT_WIDTH];
      w_m    = i_mag[k*MAG_W +: MAG_W];
      w_bext = {{(OUT_BIT_WIDTH-BIT_WIDTH){i_signed_mode & w_b[BIT_WIDTH-1]}}, w_b};
      if (i_t < w_m) begin
        if (i_neg[k]) begin
          w_sum = w_sum - w_bext;
        end else begin
          w_sum = w_sum + w_bext;
        end
      end else begin
        w_sum = w_sum;
      end
    end
  end

  // Accumulator: cleared before each pass, integrates during the pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_sum;
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/lane_temporal_mxu.sv
// -----------------------------------------------------------------------------
// lane_temporal_mxu
// OUT = A*B using DIM x LANES unary dot-product engines, one LANES-wide column
// group per pass. Pass length is max|A| (at least 1).
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   start                      : request (accepted when ready=1)
//   signed_mode, accumulate    : mode bits sampled with start
//   A, B                       : operands, element [r][c] at (r*DIM+c)*BIT_WIDTH
//   ready                      : idle
//   out                        : results, element [r][c] at (r*DIM+c)*OUT_BIT_WIDTH
//   out_valid                  : out holds a complete result
//   done                       : one-cycle completion pulse
// -----------------------------------------------------------------------------
module lane_temporal_mxu
  import mxu_pkg::*;
#(
  parameter int DIM           = 16,
  parameter int BIT_WIDTH     = 8,
  parameter int LANES         = 4,
  parameter int OUT_BIT_WIDTH = default_out_width(BIT_WIDTH, DIM)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             signed_mode,
  input  logic                             accumulate,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]     A,
  input  logic [DIM*DIM*BIT_WIDTH-1:0]     B,
  output logic                             ready,
  output logic [DIM*DIM*OUT_BIT_WIDTH-1:0] out,
  output logic                             out_valid,
  output logic                             done
);

  localparam int G     = DIM / LANES;
  localparam int MAG_W = BIT_WIDTH + 1;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int CW    = (DIM > 1) ? $clog2(DIM) : 1;

  mxu_state_t               r_state;
  logic [BIT_WIDTH-1:0]     r_a [DIM][DIM];
  logic [BIT_WIDTH-1:0]     r_b [DIM][DIM];
  logic                     r_signed;
  logic                     r_accum;
  logic [MAG_W-1:0]         r_plen;
  logic [MAG_W-1:0]         r_t;
  logic [GW-1:0]            r_group;
  logic [OUT_BIT_WIDTH-1:0] r_out [DIM][DIM];
  logic                     r_ready;
  logic                     r_done;
  logic                     r_out_valid;

  logic [DIM*MAG_W-1:0]     w_mag  [DIM];
  logic [DIM-1:0]           w_neg  [DIM];
  logic [DIM*BIT_WIDTH-1:0] w_bcol [LANES];
  logic [OUT_BIT_WIDTH-1:0] w_acc  [DIM][LANES];
  logic [MAG_W-1:0]         w_max;
  logic                     w_clear;
  logic                     w_en;

  // Per-element magnitude and sign of the captured A.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      w_mag[i] = '0;
      w_neg[i] = '0;
      for (int k = 0; k < DIM; k++) begin
        w_mag[i][k*MAG_W +: MAG_W] = MAG_W'(mag32(32'(r_a[i][k]), BIT_WIDTH, r_signed));
        w_neg[i][k]                = neg_of(32'(r_a[i][k]), BIT_WIDTH, r_signed);
      end
    end
  end

  // Largest |A| element sets the pass length.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        if (w_mag[i][k*MAG_W +: MAG_W] > w_max) begin
          w_max = w_mag[i][k*MAG_W +: MAG_W];
        end else begin
          w_max = w_max;
        end
      end
    end
  end

  // Route the B columns of the current group to the lanes.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_bcol[l] = '0;
      for (int k = 0; k < DIM; k++) begin
        w_bcol[l][k*BIT_WIDTH +: BIT_WIDTH] = r_b[k][CW'(int'(r_group) * LANES + l)];
      end
    end
  end

  // Accumulators clear in PREP and WRITE so each pass starts from zero;
  // WRITE still reads the finished value because the clear lands at its end.
  assign w_clear = (r_state == ST_PREP) || (r_state == ST_WRITE);
  assign w_en    = (r_state == ST_PASS);

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
      unary_dot_lane #(
        .DIM           (DIM),
        .BIT_WIDTH     (BIT_WIDTH),
        .OUT_BIT_WIDTH (OUT_BIT_WIDTH),
        .MAG_W         (MAG_W)
      ) u_lane (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_clear       (w_clear),
        .i_en          (w_en),
        .i_signed_mode (r_signed),
        .i_mag         (w_mag[gi]),
        .i_neg         (w_neg[gi]),
        .i_bcol        (w_bcol[gl]),
        .i_t           (r_t),
        .o_acc         (w_acc[gi][gl])
      );
    end
    for (genvar gc = 0; gc < DIM; gc++) begin : g_out
      assign out[(gi*DIM+gc)*OUT_BIT_WIDTH +: OUT_BIT_WIDTH] = r_out[gi][gc];
    end
  end

  // Control FSM with operand capture, counters and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_signed    <= 1'b0;
      r_accum     <= 1'b0;
      r_plen      <= '0;
      r_t         <= '0;
      r_group     <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          r_a[i][j]   <= '0;
          r_b[i][j]   <= '0;
          r_out[i][j] <= '0;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < DIM; i++) begin
              for (int j = 0; j < DIM; j++) begin
                r_a[i][j] <= A[(i*DIM+j)*BIT_WIDTH +: BIT_WIDTH];
                r_b[i][j] <= B[(i*DIM+j)*BIT_WIDTH +: BIT_WIDTH];
              end
            end
            r_signed    <= signed_mode;
            r_accum     <= accumulate;
            r_out_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_state     <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_plen  <= (w_max == '0) ? MAG_W'(1) : w_max;
          r_group <= '0;
          r_t     <= '0;
          r_state <= ST_PASS;
        end
        ST_PASS: begin
          if (r_t == r_plen - MAG_W'(1)) begin
            r_t     <= '0;
            r_state <= ST_WRITE;
          end else begin
            r_t <= r_t + MAG_W'(1);
          end
        end
        ST_WRITE: begin
          for (int i = 0; i < DIM; i++) begin
            for (int l = 0; l < LANES; l++) begin
              r_out[i][CW'(int'(r_group) * LANES + l)] <= r_accum ?
                r_out[i][CW'(int'(r_group) * LANES + l)] + w_acc[i][l] : w_acc[i][l];
            end
          end
          if (r_group == GW'(G - 1)) begin
            r_done      <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_FIN;
          end else begin
            r_group <= r_group + GW'(1);
            r_state <= ST_PASS;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_lane_temporal_mxu.sv
module tb_lane_temporal_mxu;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         signed_mode;
  logic         accumulate;
  logic [63:0]  A;
  logic [63:0]  B;
  logic         ready;
  logic [159:0] dut_out;
  logic         out_valid;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [159:0] model_out = '0;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sm;
    logic        acc;
    int          poke;     // cycle in which a stray start is driven (0 = none)
    int          exp_cyc;  // cycle in which done is expected
    int          hand;     // >=0: every out element equals this; <0: use model
  } vec_t;

  vec_t vecs [8];

  lane_temporal_mxu #(
    .DIM           (4),
    .BIT_WIDTH     (4),
    .LANES         (2),
    .OUT_BIT_WIDTH (10)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_mode (signed_mode),
    .accumulate  (accumulate),
    .A           (A),
    .B           (B),
    .ready       (ready),
    .out         (dut_out),
    .out_valid   (out_valid),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic int nib(input logic [63:0] m, input int idx, input logic sm);
    logic [3:0] v;
    v = m[idx*4 +: 4];
    if (sm) return int'($signed(v));
    else    return int'(v);
  endfunction

  // Plain matrix product modulo 2^10, optionally added to the previous result.
  function automatic logic [159:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input logic sm, input logic acc, input logic [159:0] prev);
    logic [159:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += nib(a, i*4+k, sm) * nib(b, k*4+c, sm);
        if (acc) s += int'(prev[(i*4+c)*10 +: 10]);
        r[(i*4+c)*10 +: 10] = s[9:0];
      end
    end
    return r;
  endfunction

  function automatic logic [159:0] fill(input int val);
    logic [159:0] r;
    for (int e = 0; e < 16; e++) r[e*10 +: 10] = val[9:0];
    return r;
  endfunction

  // Start one operation and follow it until done (bounded).
  task automatic do_run(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic sm, input logic acc, input int poke, output int done_cyc);
    bit busy_ok;
    @(negedge clk);
    A = a; B = b; signed_mode = sm; accumulate = acc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    busy_ok  = 1'b1;
    chk({nm, " valid_cleared"}, 160'(out_valid), 160'(0));
    for (int n = 1; n < 200; n++) begin
      if (done) begin
        done_cyc = n;
        break;
      end
      if (ready) busy_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; A = ~a; B = ~b; accumulate = ~acc;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, " ready_low_while_busy"}, 160'(busy_ok), 160'(1));
  endtask

  task automatic apply(input vec_t v);
    logic [159:0] e_out;
    int dc;
    int extra_done;
    int ready_drop;
    e_out = (v.hand >= 0) ? fill(v.hand) : model(v.a, v.b, v.sm, v.acc, model_out);
    do_run(v.name, v.a, v.b, v.sm, v.acc, v.poke, dc);
    chk({v.name, " done_cycle"}, 160'(dc), 160'(v.exp_cyc));
    chk({v.name, " out"}, dut_out, e_out);
    chk({v.name, " valid_at_done"}, 160'(out_valid), 160'(1));
    chk({v.name, " ready_in_fin"}, 160'(ready), 160'(0));
    @(posedge clk); #1;
    chk({v.name, " done_one_cycle"}, 160'(done), 160'(0));
    chk({v.name, " ready_after_fin"}, 160'(ready), 160'(1));
    extra_done = 0;
    ready_drop = 0;
    for (int n = 0; n < 30; n++) begin
      if (done) extra_done++;
      if (!ready) ready_drop++;
      @(posedge clk); #1;
    end
    chk({v.name, " no_extra_done"}, 160'(extra_done), 160'(0));
    chk({v.name, " stays_idle"}, 160'(ready_drop), 160'(0));
    chk({v.name, " out_held"}, dut_out, e_out);
    model_out = e_out;
  endtask

  initial begin
    vecs[0] = '{"identity",  64'h1000_0100_0010_0001, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 0,  6, -1};
    vecs[1] = '{"zero_a",    64'h0000_0000_0000_0000, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 0,  6,  0};
    vecs[2] = '{"signed_m8", 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888, 1'b1, 1'b0, 0, 20, 256};
    vecs[3] = '{"umax",      64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 5, 34, 900};
    vecs[4] = '{"umax_acc",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, 34, 776};
    vecs[5] = '{"mix_sgn",   64'h3E21_0F5B_C4A0_7129, 64'h8F7A_1234_C0DE_5B69, 1'b1, 1'b0, 9, 18, -1};
    vecs[6] = '{"mix_u_acc", 64'h1203_0210_0001_3000, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1, 0, 10, -1};
    vecs[7] = '{"post_rst",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 0, 34, 900};

    reset_n = 1'b0; start = 1'b0; signed_mode = 1'b0; accumulate = 1'b0; A = '0; B = '0;
    #12;
    chk("reset ready", 160'(ready), 160'(1));
    chk("reset done", 160'(done), 160'(0));
    chk("reset valid", 160'(out_valid), 160'(0));
    chk("reset out", dut_out, 160'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) apply(vecs[v]);

    // Reset in the middle of a pass discards everything.
    @(negedge clk);
    A = '1; B = '1; signed_mode = 1'b0; accumulate = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst out", dut_out, 160'(0));
    chk("midrst valid", 160'(out_valid), 160'(0));
    chk("midrst ready", 160'(ready), 160'(1));
    chk("midrst done", 160'(done), 160'(0));
    @(negedge clk);
    reset_n = 1'b1;
    model_out = '0;
    apply(vecs[7]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lane_temporal_mxu.md
# lane_temporal_mxu

- Parametrised successor to the single-MAC-per-row temporal matrix unit.
- Computes OUT = A·B (DIM×DIM) with DIM×LANES unary-binary dot-product engines working in parallel, one LANES-wide column group per pass.
- Adds signed/unsigned and accumulate modes, a ready/start/done handshake, and a data-dependent pass length set by the largest |A| element.
- Sits between the operand buffers and the result writeback path of the matrix datapath.

## Interface

- DIM, 16: matrix dimension.
- BIT_WIDTH, 8: operand width.
- LANES, 4: columns computed concurrently. Must divide DIM. Column groups G = DIM/LANES.
- OUT_BIT_WIDTH, 2*BIT_WIDTH+$clog2(DIM): result width.

Ports:

- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a multiply. Accepted only when ready=1.
- signed_mode  in  1  1 = A and B are two's complement; 0 = unsigned. Sampled with start.
- accumulate  in  1  1 = add results to the existing out; 0 = overwrite. Sampled with start.
- A  in  DIM×DIM×BIT_WIDTH  left operand, A[row][k].
- B  in  DIM×DIM×BIT_WIDTH  right operand, B[k][col].
- ready  out  1  idle and able to accept start.
- out  out  DIM×DIM×OUT_BIT_WIDTH  result registers, out[row][col].
- out_valid  out  1  level. High when out holds a complete result; cleared on an accepted start.
- done  out  1  one-cycle pulse on completion.

## Operation

- **States:** IDLE, PREP, PASS, WRITE, FIN.
- **IDLE:** ready=1. On start:
  - capture A, B, signed_mode and accumulate into internal registers; later input changes have no effect;
  - clear out_valid;
  - go to PREP.
- **PREP (1 cycle):**
  - M = max |A[i][k]| over all elements.
  - Unsigned: |a| = a. Signed: |a| = two's-complement magnitude, so the most negative value gives 2^(BIT_WIDTH-1).
  - Pass length P = max(M, 1). Group index g = 0. Go to PASS.
- **PASS (P cycles, pass cycle t = 0..P-1):**
  - Engine (i,l) serves column c = g*LANES+l.
  - Each cycle, for every k with t < |A[i][k]|, the engine adds B[i.e. B[k][c]] to its accumulator, or subtracts it when signed_mode and A[i][k] < 0.
  - In signed mode B is sign-extended to OUT_BIT_WIDTH; in unsigned mode it is zero-extended.
  - Accumulators clear at the start of each pass.
  - After P cycles go to WRITE.
- **WRITE (1 cycle):**
  - out[i][c] <= acc, or out[i][c] + acc when accumulate=1.
  - Arithmetic wraps modulo 2^OUT_BIT_WIDTH.
  - If g < G-1: g++, go to PASS. Otherwise go to FIN.
- **FIN (1 cycle):** done=1, out_valid<=1, go to IDLE. ready returns to 1 in the following cycle.
- **start while busy:** start in PREP, PASS, WRITE or FIN is ignored and not queued.
- **Reset (asynchronous, any state):**
  - state IDLE;
  - ready=1, done=0, out_valid=0;
  - all out registers, accumulators and captured operands cleared to 0.
- **Reset mid-operation:** the partial result is discarded. The next start runs normally. With accumulate=1 it adds to 0.

## Timing

- Accepted start at edge 0.
- PREP occupies cycle 1.
- Each group takes P+1 cycles.
- done high in cycle 1 + G*(P+1) + 1. out_valid rises at the same edge.
- out columns of group g update at the end of that group's WRITE cycle. Other columns hold their values.
- ready=0 from the cycle after an accepted start through the FIN cycle.
- Latency is deterministic given A: minimum 2+G*2 cycles when all |a| ≤ 1.

## Structure

- **Package mxu_pkg:**
  - state enum (IDLE, PREP, PASS, WRITE, FIN);
  - function for default OUT_BIT_WIDTH;
  - magnitude/sign helper functions shared with other matrix blocks.
- **Sub-module unary_dot_lane** (one per engine, DIM×LANES instances):
  - inputs: a-row magnitudes and signs, b-column, t, clear, signed_mode;
  - output: acc.
- **Top level holds:** FSM, group and t counters, max-reduction, operand capture registers and out registers.

## Test plan

All scenarios use a bench configured with DIM=4, BIT_WIDTH=4, LANES=2 (G=2, OUT_BIT_WIDTH=10).

- **Identity:** A=I, unsigned, B[k][c]=4k+c, no accumulate -> out=B; P=1; done in cycle 6; out_valid 1 from cycle 6.
- **All-zero A:** A=0, B arbitrary -> out all 0; P=1; done in cycle 6.
- **Signed negatives:** signed_mode=1, A=B=all -8 -> every out=256; P=8; done in cycle 20.
- **Unsigned max plus accumulate:**
  - First run: A=B=all 15 -> out=900; P=15; done in cycle 34.
  - Second run, accumulate=1 -> out=1800 mod 1024=776.
- **Handshake:** start pulsed during PASS -> ignored. Exactly one done. ready=0 until after FIN.
- **Reset mid-PASS:** reset_n low in cycle 5 of scenario 4 -> out=0, out_valid=0, ready=1. A fresh start with accumulate=1 -> out=900.
